// File: rtl/axis_stim_sequencer_if.sv
// AXI-Stream beat bundle for the stimulus sequencer.
// Master drives data/valid/last, slave returns ready.
interface axis_stim_sequencer_if #(
  parameter int DW = 64
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_stim_sequencer.sv
// RAM-backed AXI-Stream frame player: loads one frame,
// replays it N times (or forever) with an idle gap.
module axis_stim_sequencer #(
  parameter int WIDTH        = 16,
  parameter int SAMP_PER_CLK = 2,
  parameter int FFT_LEN      = 16,
  parameter int CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(FFT_LEN)-1:0] wr_addr,
  input  logic [2*WIDTH-1:0]         wr_data,
  input  logic [CNT_W-1:0]           cfg_num_frames,
  input  logic [CNT_W-1:0]           cfg_gap,
  input  logic                       start,
  input  logic                       abort,
  axis_stim_sequencer_if.master      m,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           frame_cnt
);
  localparam int AW = $clog2(FFT_LEN);
  localparam int SW = 2*WIDTH;
  localparam int DW = SW*SAMP_PER_CLK;
  localparam logic [AW-1:0] STEP   = AW'(SAMP_PER_CLK);
  localparam logic [AW-1:0] LAST_A = AW'(FFT_LEN - SAMP_PER_CLK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP
  } state_t;

  typedef logic [SW-1:0] ram_t [FFT_LEN];

  function automatic ram_t ram_init();
    ram_t v;
    for (int i = 0; i < FFT_LEN; i++) begin
      v[i] = SW'(WIDTH'(i));
    end
    return v;
  endfunction

  ram_t r_mem = ram_init();

  state_t           r_state;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_data;
  logic             r_valid;
  logic             r_last;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_fcnt;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] r_gcnt;

  logic [DW-1:0]    w_beat;
  logic             w_hs;
  logic             w_eof;
  logic             w_final;
  logic             w_load;

  assign w_hs    = r_valid & m.tready;
  assign w_eof   = w_hs & r_last;
  assign w_load  = ~r_valid | m.tready;
  assign w_final = (r_num != '0) &&
                   (r_fcnt + CNT_W'(1) == r_num);

  // Gather the lanes of the beat at the current read address.
  always_comb begin
    w_beat = '0;
    for (int k = 0; k < SAMP_PER_CLK; k++) begin
      w_beat[SW*k +: SW] = r_mem[r_addr + AW'(k)];
    end
  end

  // Frame RAM load port, only open while the player is idle.
  always_ff @(posedge clk) begin
    if (wr_en && !r_busy) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Run/gap sequencer with registered AXIS outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fcnt  <= '0;
      r_num   <= '0;
      r_gap   <= '0;
      r_gcnt  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num   <= cfg_num_frames;
            r_gap   <= cfg_gap;
            r_fcnt  <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_eof) begin
            r_fcnt <= r_fcnt + CNT_W'(1);
          end
          if (abort || (w_eof && w_final)) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_eof && r_gap != '0) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_gcnt  <= r_gap;
            r_state <= S_GAP;
          end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_beat;
            r_last  <= (r_addr == LAST_A);
            r_addr  <= r_addr + STEP;
          end
        end
        S_GAP: begin
          if (abort) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_gcnt == CNT_W'(1)) begin
            r_valid <= 1'b1;
            r_data  <= w_beat;
            r_last  <= (r_addr == LAST_A);
            r_addr  <= r_addr + STEP;
            r_state <= S_RUN;
          end else begin
            r_gcnt <= r_gcnt - CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m.tdata   = r_data;
  assign m.tvalid  = r_valid;
  assign m.tlast   = r_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign frame_cnt = r_fcnt;
endmodule

// File: tb/tb_axis_stim_sequencer.sv
// Randomized bench for axis_stim_sequencer against a
// frame/beat-level reference model of the player.
module tb_axis_stim_sequencer;
  localparam int WIDTH   = 16;
  localparam int SPC     = 2;
  localparam int FFT_LEN = 16;
  localparam int CNT_W   = 16;
  localparam int AW      = $clog2(FFT_LEN);
  localparam int SW      = 2*WIDTH;
  localparam int DW      = SW*SPC;
  localparam int BEATS   = FFT_LEN/SPC;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [SW-1:0]    wr_data = '0;
  logic [CNT_W-1:0] cfg_num_frames = '0;
  logic [CNT_W-1:0] cfg_gap = '0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] frame_cnt;

  logic [SW-1:0]    ram [FFT_LEN];
  int total = 0;
  int bad   = 0;

  axis_stim_sequencer_if #(.DW(DW)) axi ();

  axis_stim_sequencer #(
    .WIDTH(WIDTH),
    .SAMP_PER_CLK(SPC),
    .FFT_LEN(FFT_LEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .cfg_num_frames(cfg_num_frames),
    .cfg_gap(cfg_gap),
    .start(start),
    .abort(abort),
    .m(axi),
    .busy(busy),
    .done(done),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_beat(input int b);
    logic [DW-1:0] v;
    for (int k = 0; k < SPC; k++) begin
      v[SW*k +: SW] = ram[b*SPC + k];
    end
    return v;
  endfunction

  task automatic wr(input int a, input logic [SW-1:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    ram[a] = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // mode: 0 run to completion, 1 abort while stalled,
  // 2 abort on a tlast handshake, 3 reset on a tlast beat
  task automatic run(input int nf, input int gap, input int pct,
                     input int mode, input int mhs,
                     input bit wsame, input bit wbusy);
    int beat, frames, hs, low, cyc;
    bit watch, stall, fin, lasths, ending, quit;
    logic [DW-1:0] pdata;
    logic pl;
    beat = 0; frames = 0; hs = 0; low = 0; cyc = 0;
    watch = 0; stall = 0; fin = 0; lasths = 0;
    ending = 0; quit = 0; pdata = '0; pl = 0;
    @(posedge clk); #1;
    cfg_num_frames = CNT_W'(nf);
    cfg_gap = CNT_W'(gap);
    start = 1'b1;
    axi.tready = 1'b0;
    if (wsame) begin
      wr_en = 1'b1;
      wr_addr = AW'($urandom);
      wr_data = SW'($urandom);
      ram[wr_addr] = wr_data;
    end
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    chk("lat0", 64'(axi.tvalid), 64'(0));
    chk("busy1", 64'(busy), 64'(1));
    chk("fc0", 64'(frame_cnt), 64'(0));
    while (!quit) begin
      @(posedge clk); #1;
      cyc++;
      axi.tready = ($urandom_range(99) < pct);
      if (cyc == 3) begin
        start = 1'b1;
        cfg_num_frames = CNT_W'($urandom);
        cfg_gap = CNT_W'($urandom);
      end else begin
        start = 1'b0;
      end
      if (wbusy) begin
        wr_en = 1'b1;
        wr_addr = AW'($urandom);
        wr_data = SW'($urandom);
      end
      if (mode != 0 && hs >= mhs &&
          (mode == 1 || beat == BEATS-1)) begin
        if (mode == 3) rst = 1'b1;
        else abort = 1'b1;
        axi.tready = (mode != 1);
        ending = 1;
      end
      @(negedge clk);
      if (cyc == 1) chk("lat1", 64'(axi.tvalid), 64'(1));
      if (stall) begin
        chk("hold_v", 64'(axi.tvalid), 64'(1));
        chk("hold_d", 64'(axi.tdata), 64'(pdata));
        chk("hold_l", 64'(axi.tlast), 64'(pl));
      end
      if (lasths && !fin) begin
        chk("fcnt", 64'(frame_cnt), 64'(CNT_W'(frames)));
      end
      lasths = 0;
      if (fin) begin
        chk("done", 64'(done), 64'(1));
        chk("fin_v", 64'(axi.tvalid), 64'(0));
        chk("fin_b", 64'(busy), 64'(0));
        chk("fin_fc", 64'(frame_cnt), 64'(CNT_W'(nf)));
        wr_en = 1'b0;
        quit = 1;
      end else begin
        chk("nodone", 64'(done), 64'(0));
      end
      if (!quit) begin
        if (watch) begin
          if (!axi.tvalid) begin
            low++;
          end else begin
            chk("gap", 64'(low), 64'(gap));
            watch = 0;
          end
        end
        stall = axi.tvalid && !axi.tready;
        pdata = axi.tdata;
        pl = axi.tlast;
        if (axi.tvalid && axi.tready) begin
          chk("data", 64'(axi.tdata), 64'(exp_beat(beat)));
          chk("last", 64'(axi.tlast), 64'(beat == BEATS-1));
          hs++;
          if (beat == BEATS-1) begin
            frames++;
            beat = 0;
            lasths = 1;
            if (nf != 0 && frames == nf) begin
              fin = 1;
            end else begin
              watch = 1;
              low = 0;
            end
          end else begin
            beat++;
          end
        end
        if (ending) quit = 1;
        if (cyc > 2000) begin
          chk("timeout", 64'(1), 64'(0));
          quit = 1;
        end
      end
    end
    wr_en = 1'b0;
    if (ending && (mode == 1 || mode == 2)) begin
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("ab_v", 64'(axi.tvalid), 64'(0));
      chk("ab_done", 64'(done), 64'(1));
      chk("ab_busy", 64'(busy), 64'(0));
      chk("ab_fc", 64'(frame_cnt), 64'(CNT_W'(frames)));
      @(negedge clk);
      chk("ab_pulse", 64'(done), 64'(0));
    end
    if (ending && mode == 3) begin
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_v", 64'(axi.tvalid), 64'(0));
      chk("rst_l", 64'(axi.tlast), 64'(0));
      chk("rst_d", 64'(axi.tdata), 64'(0));
      chk("rst_b", 64'(busy), 64'(0));
      chk("rst_dn", 64'(done), 64'(0));
      chk("rst_fc", 64'(frame_cnt), 64'(0));
    end
  endtask

  initial begin
    for (int i = 0; i < FFT_LEN; i++) ram[i] = SW'(i);
    axi.tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("r_v", 64'(axi.tvalid), 64'(0));
    chk("r_l", 64'(axi.tlast), 64'(0));
    chk("r_d", 64'(axi.tdata), 64'(0));
    chk("r_b", 64'(busy), 64'(0));
    chk("r_dn", 64'(done), 64'(0));
    chk("r_fc", 64'(frame_cnt), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    run(2, 0, 100, 0, 0, 0, 0);
    run(3, 3, 100, 0, 0, 0, 0);
    run(4, 0, 50, 0, 0, 0, 0);
    run(3, 2, 50, 0, 0, 0, 0);

    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("idle_ab_dn", 64'(done), 64'(0));
    chk("idle_ab_b", 64'(busy), 64'(0));

    for (int i = 0; i < FFT_LEN; i++) begin
      wr(i, (i == 3) ? SW'(16) : SW'(0));
    end
    run(1, 0, 100, 0, 0, 0, 1);

    for (int i = 0; i < FFT_LEN; i++) wr(i, SW'($urandom));
    run(0, 0, 100, 1, 21, 0, 0);
    run(0, 0, 100, 2, 12, 0, 0);
    run(0, 0, 100, 3, 19, 0, 0);
    run(1, 2, 70, 0, 0, 1, 0);

    for (int n = 0; n < 3; n++) begin
      run($urandom_range(3, 1), $urandom_range(3, 0),
          $urandom_range(100, 30), 0, 0, 1, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
